// File: rtl/stream_width_down.sv
// Registered wide-to-narrow stream downsizer: one InBits word in, up to
// Ratio OutBits beats out, with partial final words and packet last flag.
module stream_width_down #(
    parameter int InBits   = 32,
    parameter int OutBits  = 8,
    parameter int MsbFirst = 1,
    localparam int Ratio   = InBits / OutBits,
    localparam int CntBits = $clog2(Ratio)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [InBits-1:0]  in_data,
    input  logic               in_last,
    input  logic [CntBits-1:0] in_beats,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OutBits-1:0] out_data,
    output logic               out_last
);

    logic [InBits-1:0]  sh;
    logic [CntBits-1:0] rem;
    logic               lastf;
    logic               busy;
    logic               load;
    logic               advance;
    logic               final_taken;

    // Non-power-of-2 ratios leave encodings above Ratio-1 reachable; fold them down.
    function automatic logic [CntBits-1:0] clamp_beats(input logic [CntBits-1:0] beats);
        if (int'(beats) > Ratio - 1) begin
            return CntBits'(Ratio - 1);
        end
        return beats;
    endfunction

    // Move the next slice to the emitted end, zero-filling the vacated bits.
    function automatic logic [InBits-1:0] shift_word(input logic [InBits-1:0] word);
        if (MsbFirst != 0) begin
            return word << OutBits;
        end
        return word >> OutBits;
    endfunction

    assign in_ready    = ~busy | (out_ready & (rem == '0));
    assign load        = in_valid & in_ready;
    assign advance     = busy & out_ready & (rem != '0);
    assign final_taken = busy & out_ready & (rem == '0);

    assign out_valid = busy;
    assign out_last  = busy & lastf & (rem == '0);

    generate
        if (MsbFirst != 0) begin : g_msb
            assign out_data = sh[InBits-1 -: OutBits];
        end else begin : g_lsb
            assign out_data = sh[OutBits-1:0];
        end
    endgenerate

    // A load in the final-beat cycle takes priority, so consecutive words
    // stream with no idle cycle between them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh    <= '0;
            rem   <= '0;
            lastf <= 1'b0;
            busy  <= 1'b0;
        end else if (load) begin
            sh    <= in_data;
            rem   <= clamp_beats(in_beats);
            lastf <= in_last;
            busy  <= 1'b1;
        end else if (advance) begin
            sh  <= shift_word(sh);
            rem <= rem - CntBits'(1);
        end else if (final_taken) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_width_down.sv
// Bench for stream_width_down: MSB-first and LSB-first instances share
// stimulus and are checked against a queue-of-beats reference model.
module tb_stream_width_down;

    localparam int IN  = 32;
    localparam int OUT = 8;
    localparam int R   = IN / OUT;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [IN-1:0] in_data;
    logic          in_last;
    logic [1:0]    in_beats;
    logic          out_ready;

    logic           in_ready_m, out_valid_m, out_last_m;
    logic [OUT-1:0] out_data_m;
    logic           in_ready_l, out_valid_l, out_last_l;
    logic [OUT-1:0] out_data_l;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;
    bit accepted;

    logic           obs_ready_m, obs_ready_l, obs_valid_m, obs_valid_l;
    logic           obs_last_m, obs_last_l;
    logic [OUT-1:0] obs_data_m, obs_data_l;

    // Each entry is {last, beat} as it should appear on the output.
    logic [OUT:0] qm[$];
    logic [OUT:0] ql[$];

    always #5 clk = ~clk;

    stream_width_down #(.InBits(IN), .OutBits(OUT), .MsbFirst(1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_data(in_data), .in_last(in_last), .in_beats(in_beats),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
        .out_last(out_last_m)
    );

    stream_width_down #(.InBits(IN), .OutBits(OUT), .MsbFirst(0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .in_last(in_last), .in_beats(in_beats),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
        .out_last(out_last_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word();
        int n;
        n = (int'(in_beats) > R - 1) ? R : int'(in_beats) + 1;
        for (int k = 0; k < n; k++) begin
            qm.push_back({(in_last && k == n - 1), in_data[(IN - 1 - OUT * k) -: OUT]});
            ql.push_back({(in_last && k == n - 1), in_data[(OUT * k) +: OUT]});
        end
    endtask

    // One clock: sample and check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        logic m_ready;
        #1;
        m_ready     = (qm.size() == 0) || (out_ready && qm.size() == 1);
        obs_ready_m = in_ready_m;  obs_ready_l = in_ready_l;
        obs_valid_m = out_valid_m; obs_valid_l = out_valid_l;
        obs_data_m  = out_data_m;  obs_data_l  = out_data_l;
        obs_last_m  = out_last_m;  obs_last_l  = out_last_l;
        if (check_en) begin
            chk("in_ready_msb", 32'(obs_ready_m), 32'(m_ready));
            chk("in_ready_lsb", 32'(obs_ready_l), 32'(m_ready));
            chk("out_valid_msb", 32'(obs_valid_m), 32'(qm.size() != 0));
            chk("out_valid_lsb", 32'(obs_valid_l), 32'(ql.size() != 0));
            if (qm.size() != 0) begin
                chk("out_data_msb", 32'(obs_data_m), 32'(qm[0][OUT-1:0]));
                chk("out_last_msb", 32'(obs_last_m), 32'(qm[0][OUT]));
                chk("out_data_lsb", 32'(obs_data_l), 32'(ql[0][OUT-1:0]));
                chk("out_last_lsb", 32'(obs_last_l), 32'(ql[0][OUT]));
            end else begin
                chk("idle_last_msb", 32'(obs_last_m), 32'd0);
                chk("idle_last_lsb", 32'(obs_last_l), 32'd0);
            end
        end
        accepted = in_valid && m_ready && !rst;
        @(posedge clk);
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() != 0 && out_ready) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (accepted) push_word();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [OUT-1:0] exp_m [8];
        logic [OUT-1:0] exp_l [8];
        int words;
        int cyc;
        exp_m = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_l = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};

        // Reset with a word offered throughout
        rst = 1; in_valid = 1; in_data = 32'h5A5A5A5A; in_beats = 2'd3; in_last = 1; out_ready = 1;
        step();
        check_en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_valid", 32'(obs_valid_m), 32'd0);
            chk("rst_data_msb", 32'(obs_data_m), 32'd0);
            chk("rst_data_lsb", 32'(obs_data_l), 32'd0);
            chk("rst_last", 32'(obs_last_m), 32'd0);
            chk("rst_ready", 32'(obs_ready_m), 32'd1);
        end
        rst = 0; in_valid = 0;
        step();
        chk("post_rst_valid", 32'(obs_valid_m), 32'd0);
        chk("post_rst_data", 32'(obs_data_m), 32'd0);

        // Back-to-back full words
        in_valid = 1; in_data = 32'hAABBCCDD; in_beats = 2'd3; in_last = 0; out_ready = 1;
        step();
        chk("b2b_first_ready", 32'(obs_ready_m), 32'd1);
        in_data = 32'h11223344; in_last = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) in_valid = 0;
            step();
            chk("b2b_valid", 32'(obs_valid_m), 32'd1);
            chk("b2b_data_msb", 32'(obs_data_m), 32'(exp_m[i]));
            chk("b2b_data_lsb", 32'(obs_data_l), 32'(exp_l[i]));
            chk("b2b_ready", 32'(obs_ready_m), 32'(i == 3 || i == 7));
            chk("b2b_last", 32'(obs_last_m), 32'(i == 7));
        end
        step();
        chk("b2b_idle", 32'(obs_valid_m), 32'd0);

        // Partial word, then the next word with no bubble
        in_valid = 1; in_data = 32'hDEADBEEF; in_beats = 2'd1; in_last = 1;
        step();
        in_data = 32'hCAFEF00D; in_beats = 2'd3; in_last = 1;
        step();
        chk("part_b0_msb", 32'(obs_data_m), 32'hDE);
        chk("part_b0_lsb", 32'(obs_data_l), 32'hEF);
        chk("part_b0_last", 32'(obs_last_m), 32'd0);
        step();
        chk("part_b1_msb", 32'(obs_data_m), 32'hAD);
        chk("part_b1_lsb", 32'(obs_data_l), 32'hBE);
        chk("part_b1_last", 32'(obs_last_m), 32'd1);
        chk("part_b1_ready", 32'(obs_ready_m), 32'd1);
        in_valid = 0;
        step();
        chk("part_next_valid", 32'(obs_valid_m), 32'd1);
        chk("part_next_msb", 32'(obs_data_m), 32'hCA);
        chk("part_next_lsb", 32'(obs_data_l), 32'h0D);
        repeat (3) step();

        // Single-beat word
        in_valid = 1; in_data = 32'hAABBCCDD; in_beats = 2'd0; in_last = 1;
        step();
        in_valid = 0;
        step();
        chk("one_msb", 32'(obs_data_m), 32'hAA);
        chk("one_lsb", 32'(obs_data_l), 32'hDD);
        chk("one_last", 32'(obs_last_l), 32'd1);
        step();
        chk("one_idle", 32'(obs_valid_l), 32'd0);

        // Reset mid-word discards the remaining beats
        in_valid = 1; in_data = 32'hAABBCCDD; in_beats = 2'd3; in_last = 0;
        step();
        in_valid = 0;
        step();
        step();
        rst = 1;
        step();
        chk("midrst_cc", 32'(obs_data_m), 32'hCC);
        rst = 0; in_valid = 1; in_data = 32'h01020304; in_beats = 2'd3; in_last = 1;
        step();
        chk("midrst_valid", 32'(obs_valid_m), 32'd0);
        chk("midrst_ready", 32'(obs_ready_m), 32'd1);
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_msb", 32'(obs_data_m), 32'(i + 1));
            chk("midrst_lsb", 32'(obs_data_l), 32'(4 - i));
        end

        // Random words under random backpressure
        words = 0;
        cyc = 0;
        while (words < 200 && cyc < 20000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1;
                in_data  = $urandom;
                in_beats = 2'($urandom_range(0, 3));
                in_last  = 1'($urandom_range(0, 1));
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (accepted) begin
                words++;
                in_valid = 0;
            end
            cyc++;
        end
        chk("rand_words_done", 32'(words), 32'd200);
        in_valid = 0; out_ready = 1;
        cyc = 0;
        while (qm.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        step();
        chk("drain_idle", 32'(obs_valid_m), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_width_down.md
# stream_width_down

Registered stream width downsizer. Takes one wide word per handshake, for example a packed capture sample or a trace record, and emits it as a sequence of narrower beats on a valid/ready stream. It sits directly upstream of the 1-deep stream buffer that feeds the byte-wide output path (UART/USB TX). It supports partial final words and propagates a packet `last` flag to the final narrow beat. It uses the same handshake rules as the rest of the stream library.

## Interface
- `InBits`, 32: input word width; must be an integer multiple of `OutBits`.
- `OutBits`, 8: output beat width.
- `MsbFirst`, 1: 1 = most-significant slice emitted first; 0 = least-significant slice first.
- Derived: `Ratio = InBits/OutBits` (≥2 required); `CntBits = clog2(Ratio)`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when high with `in_valid`; combinational.
- `in_data`  in  InBits  input word.
- `in_last`  in  1  word is the final word of a packet.
- `in_beats`  in  CntBits  number of valid beats in the word, minus 1; 0 = one beat.
- `out_valid`  out  1  output beat valid; registered.
- `out_ready`  in  1  downstream ready.
- `out_data`  out  OutBits  output beat; registered.
- `out_last`  out  1  final beat of a packet; registered.

## Operation
- Internal state:
  - `sh`: word shift register, InBits wide.
  - `rem`: remaining beats after the current one, CntBits wide.
  - `lastf`: latched `in_last`.
  - `busy`, which drives `out_valid`.
- `out_data` slice of `sh`: `sh[InBits-1 -: OutBits]` when MsbFirst=1, otherwise `sh[OutBits-1:0]`.
- `out_last = busy & lastf & (rem == 0)`.
- Input ready: `in_ready = ~busy | (out_ready & rem == 0)`.
- Load (`in_valid & in_ready`):
  - `sh <= in_data`.
  - `rem <= min(in_beats, Ratio-1)`.
  - `lastf <= in_last`.
  - `busy <= 1`.
- Advance (`busy & out_ready & rem != 0`):
  - `sh` shifts by OutBits toward the emitted end; vacated bits are zero-filled.
  - `rem <= rem - 1`.
- Final beat consumed with no new load: `busy <= 0`.
- Final beat consumed with a simultaneous load: the load wins and there is no bubble.
- Slices beyond `in_beats` are never emitted. Their contents are don't-care.
- `in_beats` greater than Ratio-1 (non-power-of-2 Ratio only) is clamped to Ratio-1.
- `in_last` is ignored except on the final beat. A partial word with `in_last = 0` is legal and simply emits fewer beats.
- Reset:
  - `busy`, `rem`, `lastf` and `sh` go to 0.
  - Therefore `out_valid = 0`, `out_data = 0`, `out_last = 0`, and `in_ready = 1` during and after reset.
- Reset mid-word discards the remaining beats. The first word after reset starts at beat 0.

## Timing
- Latency: a word accepted at edge N presents its first beat from cycle N+1. There is no combinational path from `in_data` to `out_data`.
- Throughput with `out_ready` held high: 1 beat per cycle.
  - Full words produce Ratio beats per word, back-to-back with zero idle cycles between words.
  - `in_ready` is high only in the cycle the final beat is presented.
- Backpressure: while `out_valid & ~out_ready`, `out_data`, `out_last` and `rem` hold stable, and `in_ready = 0`.
- Dependencies: `in_ready` depends combinationally on `out_ready` and on state only. It never depends on `in_valid`.
- Once asserted, `out_valid` never drops until the beat is accepted.

## Test plan
Parameters for all cases are InBits=32, OutBits=8, MsbFirst=1 unless stated.

1. Reset check: hold `rst` for 3 cycles with `in_valid = 1` -> `out_valid = 0`, `out_data = 0`, `out_last = 0`, `in_ready = 1`. No word is accepted until `rst` falls.
2. Back-to-back words with `out_ready = 1`:
   - Stimulus: `0xAABBCCDD` (beats=3, last=0), then `0x11223344` (beats=3, last=1) offered immediately.
   - Required: `AA BB CC DD 11 22 33 44` on 8 consecutive cycles.
   - `out_last` is high only on `44`.
   - `in_ready` is high only on the `DD` and `44` cycles.
3. Random backpressure: `out_ready` random at 50% over 200 random words with random `in_beats`/`in_last` -> the output sequence matches the reference model. `out_data`/`out_last` stay stable on every stalled cycle.
4. Partial word: `0xDEADBEEF` with beats=1, last=1 -> `DE`, then `AD` with `out_last = 1`. `BE`/`EF` are never emitted and the next word follows with no bubble.
5. LSB-first: MsbFirst=0, `0xAABBCCDD` with beats=3 -> `DD CC BB AA`. Partial beats=0 -> `DD` only.
6. Reset mid-word: assert `rst` after `AA`, `BB` are consumed -> `out_valid = 0` the next cycle. The next word `0x01020304` emits `01 02 03 04`, with no stale `CC`/`DD`.
